// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: drives the PLL reset, qualifies lock over a
// stability window and releases downstream reset, re-arming the PLL on lock
// loss or lock timeout and parking in FAIL after too many failed attempts.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 36000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             retry,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             lock_lost,
    output logic             fail,
    output logic [CNT_W-1:0] relock_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int T_MAX_RS = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX    = (T_MAX_RS > STABLE_CYCLES) ? T_MAX_RS : STABLE_CYCLES;
    localparam int TIMER_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0]   RELOCK_MAX   = '1;

    state_t             cur_state;
    state_t             nxt_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_cnt_nxt;
    logic [RETRY_W-1:0] retry_inc;
    logic [CNT_W-1:0]   relock_nxt;
    logic               lock_lost_nxt;
    logic               sync_meta;
    logic               locked_s;

    assign state     = cur_state;
    assign retry_inc = retry_cnt + RETRY_W'(1);

    // Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so they register alongside it.
    always_comb begin
        nxt_state     = cur_state;
        retry_cnt_nxt = retry_cnt;
        relock_nxt    = relock_count;
        lock_lost_nxt = 1'b0;
        case (cur_state)
            S_RESET_PLL: begin
                if (timer == RST_LAST) nxt_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    nxt_state = S_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_cnt_nxt = retry_inc;
                    nxt_state     = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    retry_cnt_nxt = retry_inc;
                    nxt_state     = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET_PLL;
                end else if (timer == STABLE_LAST) begin
                    retry_cnt_nxt = '0;
                    nxt_state     = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    nxt_state     = S_RESET_PLL;
                    lock_lost_nxt = 1'b1;
                    if (relock_count != RELOCK_MAX) relock_nxt = relock_count + CNT_W'(1);
                end
            end
            S_FAIL: begin
                if (retry) begin
                    retry_cnt_nxt = '0;
                    nxt_state     = S_RESET_PLL;
                end
            end
            default: nxt_state = S_RESET_PLL;
        endcase

        // Timer restarts on every transition and idles at zero where no window is timed.
        if ((nxt_state != cur_state) || (cur_state == S_RUN) || (cur_state == S_FAIL))
            timer_nxt = '0;
        else
            timer_nxt = timer + TIMER_W'(1);
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            cur_state    <= S_RESET_PLL;
            timer        <= '0;
            retry_cnt    <= '0;
            relock_count <= '0;
            lock_lost    <= 1'b0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            fail         <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            timer        <= timer_nxt;
            retry_cnt    <= retry_cnt_nxt;
            relock_count <= relock_nxt;
            lock_lost    <= lock_lost_nxt;
            pll_rst      <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
            sys_rst_n    <= (nxt_state == S_RUN);
            fail         <= (nxt_state == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       retry;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [1:0] relock_count;
    logic [2:0] state;

    int applied = 0;
    int miss    = 0;

    typedef struct {
        logic       rst_n;
        logic       locked;
        logic       retry;
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       ll;
        logic       fl;
        logic [1:0] rc;
    } vec_t;

    vec_t tbl[15];

    pll_lock_supervisor #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2), .CNT_W(2)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .retry(retry),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_lost(lock_lost), .fail(fail),
        .relock_count(relock_count), .state(state)
    );

    always #5 refclk = ~refclk;

    function automatic vec_t mk(input logic r, input logic l, input logic t, input logic [2:0] st,
                                input logic p, input logic s, input logic ll, input logic fl,
                                input logic [1:0] rc);
        vec_t v;
        v.rst_n = r; v.locked = l; v.retry = t; v.st = st;
        v.prst = p; v.srst = s; v.ll = ll; v.fl = fl; v.rc = rc;
        return v;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic p, input logic s,
                         input logic ll, input logic fl, input logic [1:0] rc);
        applied++;
        if ({state, pll_rst, sys_rst_n, lock_lost, fail, relock_count} !== {st, p, s, ll, fl, rc}) begin
            miss++;
            $display("FAIL %s: got state=%0d pll_rst=%b sys_rst_n=%b lock_lost=%b fail=%b relock=%0d, want state=%0d pll_rst=%b sys_rst_n=%b lock_lost=%b fail=%b relock=%0d",
                     name, state, pll_rst, sys_rst_n, lock_lost, fail, relock_count, st, p, s, ll, fl, rc);
        end
    endtask

    // From a reset edge or RESET_PLL entry (lock already held): WAIT_LOCK on the 4th edge, STABLE on the 5th.
    task automatic to_stable(input logic [1:0] rc);
        repeat (3) tick();
        tick(); check("to_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        tick(); check("to_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, rc);
    endtask

    // One-cycle low glitch on pll_locked while in STABLE; seen by the FSM on the 3rd edge.
    task automatic glitch(input string name, input logic [2:0] st_after, input logic [1:0] rc);
        pll_locked = 1'b0;
        tick(); check({name, "_g1"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        pll_locked = 1'b1;
        tick(); check({name, "_g2"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        tick(); check({name, "_g3"}, st_after, 1'b1, 1'b0, 1'b0, st_after == 3'd4, rc);
    endtask

    // One-cycle lock drop in RUN, then full re-lock back to RUN.
    task automatic loss(input logic [1:0] rc_before, input logic [1:0] rc_after);
        pll_locked = 1'b0;
        tick(); check("loss_e1", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, rc_before);
        pll_locked = 1'b1;
        tick(); check("loss_e2", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, rc_before);
        tick(); check("loss_e3", 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, rc_after);
        tick(); check("loss_e4", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, rc_after);
        repeat (11) tick();
        check("relock_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, rc_after);
        tick(); check("relock_run", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, rc_after);
    endtask

    initial begin
        rst_n = 1'b0; pll_locked = 1'b1; retry = 1'b0;

        // Power-up with lock held: 4 RESET_PLL cycles, WAIT_LOCK, 8 STABLE cycles, RUN.
        tbl[0] = mk(0, 1, 0, 3'd0, 1, 0, 0, 0, 2'd0);
        tbl[1] = mk(0, 1, 0, 3'd0, 1, 0, 0, 0, 2'd0);
        for (int i = 2; i <= 4; i++) tbl[i] = mk(1, 1, 0, 3'd0, 1, 0, 0, 0, 2'd0);
        tbl[5] = mk(1, 1, 0, 3'd1, 0, 0, 0, 0, 2'd0);
        for (int i = 6; i <= 13; i++) tbl[i] = mk(1, 1, 0, 3'd2, 0, 0, 0, 0, 2'd0);
        tbl[14] = mk(1, 1, 0, 3'd3, 0, 1, 0, 0, 2'd0);

        for (int i = 0; i < 15; i++) begin
            rst_n = tbl[i].rst_n; pll_locked = tbl[i].locked; retry = tbl[i].retry;
            tick();
            check($sformatf("powerup_%0d", i), tbl[i].st, tbl[i].prst, tbl[i].srst,
                  tbl[i].ll, tbl[i].fl, tbl[i].rc);
        end

        // Five lock losses in RUN: relock_count saturates at 3.
        loss(2'd0, 2'd1);
        loss(2'd1, 2'd2);
        loss(2'd2, 2'd3);
        loss(2'd3, 2'd3);
        loss(2'd3, 2'd3);

        // Reset mid-RUN.
        rst_n = 1'b0;
        tick(); check("rst_mid_run", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;

        // Glitches in STABLE: first retries, second fails.
        to_stable(2'd0);
        glitch("stable_glitch1", 3'd0, 2'd0);
        to_stable(2'd0);
        glitch("stable_glitch2", 3'd4, 2'd0);
        repeat (3) begin
            tick(); check("fail_hold", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        end
        retry = 1'b1;
        tick(); check("fail_retry", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        retry = 1'b0;
        to_stable(2'd0);
        glitch("after_retry_glitch", 3'd0, 2'd0);

        // Reset mid-STABLE.
        to_stable(2'd0);
        rst_n = 1'b0;
        tick(); check("rst_mid_stable", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // No lock ever: two 20-cycle windows split by a 4-cycle RESET_PLL, then FAIL.
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tick(); check("to_wait1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (19) tick();
        check("wait1_last", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(); check("timeout1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (3) tick();
        check("reset2_last", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(); check("to_wait2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        repeat (19) tick();
        check("wait2_last", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(); check("timeout_fail", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
        retry = 1'b1;
        tick(); check("timeout_retry", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        retry = 1'b0;

        // Lock arriving on the exact timeout cycle wins over the retry.
        rst_n = 1'b0;
        tick(); check("rst_again", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        repeat (21) tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        check("edge_wait_last", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        tick(); check("edge_lock_wins", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the reset and lock handshake of the 96/48 MHz clock PLL from the consumer side. It drives the PLL `rst` input and watches the PLL `locked` output. It releases downstream reset only after lock has been stable for a qualified period, and it re-arms the PLL on lock loss or timeout. It runs on the free-running 360 MHz reference clock, alongside the PLL wrapper in the clocking top level.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 36000: cycles allowed in WAIT_LOCK before a retry (100 µs at 360 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized locked cycles required before downstream release.
- MAX_RETRIES, 7: failed attempts tolerated before entering FAIL (≥1).
- CNT_W, 8: width of `relock_count`.

Ports:
- refclk, input, 1: reference clock; sole clock.
- rst_n, input, 1: synchronous active-low reset.
- pll_locked, input, 1: PLL `locked`; asynchronous, 2-FF synchronized internally.
- retry, input, 1: one-cycle pulse; exits FAIL.
- pll_rst, output, 1: to PLL `rst`, active high.
- sys_rst_n, output, 1: downstream reset, active low.
- lock_lost, output, 1: one-cycle pulse on loss of lock while in RUN.
- fail, output, 1: high while in FAIL.
- relock_count, output, CNT_W: saturating count of RUN lock losses.
- state, output, 3: encoded FSM state (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).

Behaviour:
- Single clock domain is `refclk`. Reset is synchronous and active-low on `rst_n`, sampled on the `refclk` rising edge.
- Reset state while `rst_n`=0:
  - state=RESET_PLL, pll_rst=1, sys_rst_n=0, lock_lost=0, fail=0.
  - relock_count=0, retry_cnt=0, timer=0, both sync flops=0.
- `locked_s` is `pll_locked` after 2 flops, giving 2 cycles of latency.
- Outputs are registered and Moore-decoded from state, except `lock_lost`, which is a registered pulse.
- RESET_PLL:
  - pll_rst=1, sys_rst_n=0.
  - Timer counts 0..RST_CYCLES-1, then go to WAIT_LOCK with timer cleared.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE with timer cleared.
  - Else, if timer=LOCK_TIMEOUT-1, increment retry_cnt. Go to FAIL if the new value equals MAX_RETRIES, otherwise to RESET_PLL.
  - Lock and timeout in the same cycle: lock wins.
- STABLE:
  - pll_rst=0, sys_rst_n=0.
  - If locked_s=0, increment retry_cnt and take the same FAIL/RESET_PLL decision as a WAIT_LOCK timeout.
  - Else, when timer=STABLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN:
  - sys_rst_n=1.
  - If locked_s=0: go to RESET_PLL, assert lock_lost for exactly 1 cycle (coincident with the state change), and increment relock_count, saturating at 2^CNT_W-1.
- FAIL:
  - pll_rst=1, sys_rst_n=0, fail=1.
  - `retry`=1 goes to RESET_PLL, clearing retry_cnt and timer. `retry` is ignored in all other states.
- End-to-end latency: a `pll_locked` fall in RUN drives sys_rst_n low and pll_rst high 3 refclk edges later.
- `rst_n` asserted mid-operation forces the reset state on the next edge regardless of state or timer.
- Timer width is ceil(log2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))). The timer is cleared on every state transition.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2.
1. Release rst_n with pll_locked=1 held → pll_rst high for 4 cycles, then STABLE 2 cycles later; sys_rst_n rises after 8 more cycles; retry_cnt=0.
2. pll_locked=0 forever → two 20-cycle WAIT_LOCK windows separated by a 4-cycle RESET_PLL; then state=FAIL, fail=1, pll_rst=1; a retry pulse returns to RESET_PLL.
3. In RUN, drop pll_locked for 1 cycle → lock_lost pulses once, relock_count=1, sys_rst_n=0 on the 3rd edge; the sequence then re-locks to RUN.
4. Repeat lock loss 5 times → relock_count saturates at 3.
5. Glitch pll_locked low during STABLE → RESET_PLL, retry_cnt=1; a second glitch → FAIL.
6. Assert rst_n=0 mid-STABLE and mid-RUN → next edge shows state=RESET_PLL and all outputs at their reset values; check that locked rising on the exact timeout cycle enters STABLE, not RESET_PLL.
